// File: rtl/axil_aw_fifo.sv
// AXI4-Lite write-address slave: DEPTH-entry FWFT buffer with region/alignment response precompute.
// Optional macro AXIL_AW_PROT_CHECK_EN makes non-secure (AWPROT[1]) accesses return DECERR.
module axil_aw_fifo #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] REGION_SIZE = 32'h0000_1000
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [ADDR_WIDTH-1:0]     AWADDR,
  input  logic [2:0]                AWPROT,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [ADDR_WIDTH-1:0]     o_addr,
  output logic [2:0]                o_prot,
  output logic [1:0]                o_resp,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ALIGN_BITS = $clog2(DATA_WIDTH / 8);
  // One extra bit so a region ending at the top of the address space does not wrap to zero.
  localparam logic [ADDR_WIDTH:0] REGION_END = {1'b0, BASE_ADDR} + {1'b0, REGION_SIZE};

  logic [ADDR_WIDTH-1:0] addrMem_q [DEPTH];
  logic [2:0]            protMem_q [DEPTH];
  logic [1:0]            respMem_q [DEPTH];

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rstDone_q;

  logic       push, pop;
  logic       misaligned, outOfRange, protErr;
  logic [1:0] respNew;

  assign AWREADY = rstDone_q && (count_q != CNT_W'(DEPTH));
  assign o_valid = (count_q != '0);
  assign o_count = count_q;
  assign push    = AWVALID && AWREADY;
  assign pop     = o_valid && i_ready;

`ifdef AXIL_AW_PROT_CHECK_EN
  assign protErr = AWPROT[1];
`else
  assign protErr = 1'b0;
`endif

  always_comb begin
    misaligned = (AWADDR[ALIGN_BITS-1:0] != '0);
    outOfRange = ({1'b0, AWADDR} < {1'b0, BASE_ADDR}) || ({1'b0, AWADDR} >= REGION_END);
    respNew    = 2'b00;
    if (outOfRange || protErr) begin
      respNew = 2'b11;
    end else if (misaligned) begin
      respNew = 2'b10;
    end
  end

  always_comb begin
    wrPtr_d = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
    rdPtr_d = pop ? rdPtr_q + PTR_W'(1) : rdPtr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      rstDone_q <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      rstDone_q <= 1'b1;
    end
  end

  // Entry storage needs no reset: the head is masked whenever the buffer is empty.
  always_ff @(posedge ACLK) begin
    if (push) begin
      addrMem_q[wrPtr_q] <= AWADDR;
      protMem_q[wrPtr_q] <= AWPROT;
      respMem_q[wrPtr_q] <= respNew;
    end
  end

  always_comb begin
    o_addr = '0;
    o_prot = '0;
    o_resp = 2'b00;
    if (o_valid) begin
      o_addr = addrMem_q[rdPtr_q];
      o_prot = protMem_q[rdPtr_q];
      o_resp = respMem_q[rdPtr_q];
    end
  end

endmodule
